// File: rtl/lupdate.sv
`default_nettype none
// ============================================================================
// Module      : lupdate
// Description : Beacon-update receiver on the 134-bit CNC packet stream.
//               Packets are classified at their Ethernet header (word 2).
//               Beacon updates addressed to this node are consumed: their
//               beacon word (word 6) is committed to the local configuration
//               registers and beacon_update_master toggles. All other
//               traffic passes through with a fixed 4-cycle latency.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   in_lu_data_wr/_data      : input word strobe / word ([133:132] marker:
//                              01 head, 11 middle, 10 tail)
//   in_lu_data_valid(_wr)    : packet-valid and its strobe (tail word)
//   in_local_mac_id          : this node's MAC address (quasi-static)
//   out_lu_*                 : forwarded stream, 4 cycles behind the input
//   direction, token_bucket_para, direct_mac_addr, time_slot_period
//                            : committed beacon registers
//   beacon_update_master     : toggles once per committed update
//   upd_cnt / upd_err_cnt    : committed / truncated update counters (wrap)
//
// Revision    : 1.0 - initial release
// ============================================================================
module lupdate #(
    parameter logic [15:0] ETH_TYPE  = 16'h88f7,
    parameter logic [3:0]  UPD_TYPE  = 4'hd,
    parameter int          MIN_WORDS = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_lu_data_wr,
    input  logic [133:0] in_lu_data,
    input  logic         in_lu_data_valid,
    input  logic         in_lu_data_valid_wr,
    input  logic [47:0]  in_local_mac_id,
    output logic         out_lu_data_wr,
    output logic [133:0] out_lu_data,
    output logic         out_lu_data_valid,
    output logic         out_lu_data_valid_wr,
    output logic         direction,
    output logic [31:0]  token_bucket_para,
    output logic [47:0]  direct_mac_addr,
    output logic [31:0]  time_slot_period,
    output logic         beacon_update_master,
    output logic [31:0]  upd_cnt,
    output logic [31:0]  upd_err_cnt
);

    localparam logic [1:0] c_MK_HEAD = 2'b01;
    localparam logic [1:0] c_MK_TAIL = 2'b10;

    // Word counters only need to reach the beacon word; they saturate beyond.
    localparam int                 c_CNT_W      = $clog2(MIN_WORDS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX    = '1;
    localparam logic [c_CNT_W-1:0] c_HDR_IDX    = c_CNT_W'(2);
    localparam logic [c_CNT_W-1:0] c_BEACON_IDX = c_CNT_W'(MIN_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_FWD  = 2'd2,
        S_UPD  = 2'd3
    } state_t;

    function automatic logic f_is_upd(
        input logic [47:0] dmac,
        input logic [15:0] eth,
        input logic [3:0]  typ,
        input logic [47:0] mac
    );
        return (dmac == mac) && (eth == ETH_TYPE) && (typ == UPD_TYPE);
    endfunction

    // ------------------------------------------------------------------
    // Delay line s0 -> s1 -> s2, plus the word index of the word in s0
    // ------------------------------------------------------------------
    logic               r_s0_wr, r_s1_wr, r_s2_wr;
    logic [133:0]       r_s0_data, r_s1_data, r_s2_data;
    logic               r_s0_valid, r_s1_valid, r_s2_valid;
    logic               r_s0_vwr, r_s1_vwr, r_s2_vwr;
    logic [c_CNT_W-1:0] r_s0_idx;
    logic               r_drop_flag;

    logic w_in_head;
    logic w_in_tail;
    logic w_in_match;
    logic w_s2_head;
    logic w_s2_tail;
    logic w_cls;
    logic w_drop;

    assign w_in_head  = in_lu_data_wr && (in_lu_data[133:132] == c_MK_HEAD);
    assign w_in_tail  = in_lu_data_wr && (in_lu_data[133:132] == c_MK_TAIL);
    assign w_in_match = f_is_upd(in_lu_data[127:80], in_lu_data[31:16],
                                 in_lu_data[11:8], in_local_mac_id);

    assign w_s2_head = r_s2_wr && (r_s2_data[133:132] == c_MK_HEAD);
    assign w_s2_tail = r_s2_wr && (r_s2_data[133:132] == c_MK_TAIL);

    // Word 2 in s0 means the head of the same packet is in s2, so the
    // decision lands exactly on the first word leaving the delay line.
    assign w_cls = r_s0_wr && (r_s0_idx == c_HDR_IDX) &&
                   f_is_upd(r_s0_data[127:80], r_s0_data[31:16],
                            r_s0_data[11:8], in_local_mac_id);

    // A head reaching s2 without a fresh match ends any stale drop (e.g. an
    // update abandoned by a new head before its tail).
    assign w_drop = w_cls || (r_drop_flag && !w_s2_head);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_wr    <= 1'b0;
            r_s0_data  <= '0;
            r_s0_valid <= 1'b0;
            r_s0_vwr   <= 1'b0;
            r_s1_wr    <= 1'b0;
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_vwr   <= 1'b0;
            r_s2_wr    <= 1'b0;
            r_s2_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_vwr   <= 1'b0;
            r_s0_idx   <= '0;
        end else begin
            r_s0_wr    <= in_lu_data_wr;
            r_s0_data  <= in_lu_data;
            r_s0_valid <= in_lu_data_valid;
            r_s0_vwr   <= in_lu_data_valid_wr;
            r_s1_wr    <= r_s0_wr;
            r_s1_data  <= r_s0_data;
            r_s1_valid <= r_s0_valid;
            r_s1_vwr   <= r_s0_vwr;
            r_s2_wr    <= r_s1_wr;
            r_s2_data  <= r_s1_data;
            r_s2_valid <= r_s1_valid;
            r_s2_vwr   <= r_s1_vwr;
            if (in_lu_data_wr) begin
                if (w_in_head) begin
                    r_s0_idx <= '0;
                end else if (r_s0_idx != c_CNT_MAX) begin
                    r_s0_idx <= r_s0_idx + 1'b1;
                end
            end
        end
    end

    // Output register and drop flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_lu_data_wr       <= 1'b0;
            out_lu_data          <= '0;
            out_lu_data_valid    <= 1'b0;
            out_lu_data_valid_wr <= 1'b0;
            r_drop_flag          <= 1'b0;
        end else begin
            if (w_drop) begin
                out_lu_data_wr       <= 1'b0;
                out_lu_data          <= '0;
                out_lu_data_valid    <= 1'b0;
                out_lu_data_valid_wr <= 1'b0;
            end else begin
                out_lu_data_wr       <= r_s2_wr;
                out_lu_data          <= r_s2_data;
                out_lu_data_valid    <= r_s2_valid;
                out_lu_data_valid_wr <= r_s2_vwr;
            end
            r_drop_flag <= w_drop && !w_s2_tail;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM (input side): latches the beacon word and commits
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [c_CNT_W-1:0] r_word_cnt;
    logic               r_shadow_ok;
    logic [47:0]        r_sh_mac;
    logic               r_sh_dir;
    logic [31:0]        r_sh_tb;
    logic [31:0]        r_sh_ts;

    logic        w_at_beacon;
    logic [47:0] w_bcn_mac;
    logic        w_bcn_dir;
    logic [31:0] w_bcn_tb;
    logic [31:0] w_bcn_ts;

    // A tail that is itself the beacon word commits straight from the input.
    assign w_at_beacon = (r_word_cnt == c_BEACON_IDX);
    assign w_bcn_mac   = w_at_beacon ? in_lu_data[127:80] : r_sh_mac;
    assign w_bcn_dir   = w_at_beacon ? in_lu_data[79]     : r_sh_dir;
    assign w_bcn_tb    = w_at_beacon ? in_lu_data[63:32]  : r_sh_tb;
    assign w_bcn_ts    = w_at_beacon ? in_lu_data[31:0]   : r_sh_ts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state              <= S_IDLE;
            r_word_cnt           <= '0;
            r_shadow_ok          <= 1'b0;
            r_sh_mac             <= '0;
            r_sh_dir             <= 1'b0;
            r_sh_tb              <= '0;
            r_sh_ts              <= '0;
            direction            <= 1'b0;
            token_bucket_para    <= '0;
            direct_mac_addr      <= '0;
            time_slot_period     <= '0;
            beacon_update_master <= 1'b0;
            upd_cnt              <= '0;
            upd_err_cnt          <= '0;
        end else if (in_lu_data_wr) begin
            if (w_in_head) begin
                // Any head restarts; an unfinished update is silently dropped.
                r_state     <= S_HDR;
                r_word_cnt  <= c_CNT_W'(1);
                r_shadow_ok <= 1'b0;
            end else begin
                case (r_state)
                    S_HDR: begin
                        if (r_word_cnt == c_HDR_IDX) begin
                            if (w_in_match) begin
                                if (w_in_tail) begin
                                    // Matched header with nothing after it.
                                    upd_err_cnt <= upd_err_cnt + 32'd1;
                                    r_state     <= S_IDLE;
                                end else begin
                                    r_state    <= S_UPD;
                                    r_word_cnt <= r_word_cnt + 1'b1;
                                end
                            end else begin
                                r_state <= w_in_tail ? S_IDLE : S_FWD;
                            end
                        end else if (w_in_tail) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end
                    S_FWD: begin
                        if (w_in_tail) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_UPD: begin
                        if (w_at_beacon) begin
                            r_sh_mac    <= in_lu_data[127:80];
                            r_sh_dir    <= in_lu_data[79];
                            r_sh_tb     <= in_lu_data[63:32];
                            r_sh_ts     <= in_lu_data[31:0];
                            r_shadow_ok <= 1'b1;
                        end
                        if (r_word_cnt != c_CNT_MAX) begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                        if (w_in_tail) begin
                            if (r_shadow_ok || w_at_beacon) begin
                                direct_mac_addr      <= w_bcn_mac;
                                direction            <= w_bcn_dir;
                                token_bucket_para    <= w_bcn_tb;
                                time_slot_period     <= w_bcn_ts;
                                beacon_update_master <= ~beacon_update_master;
                                upd_cnt              <= upd_cnt + 32'd1;
                            end else begin
                                upd_err_cnt <= upd_err_cnt + 32'd1;
                            end
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lupdate.sv
`default_nettype none
// ============================================================================
// Module      : tb_lupdate
// Description : Self-checking bench for lupdate. A packet-level model builds
//               the expected output stream and beacon register state for a
//               directed table of packets followed by random traffic; a
//               hand-written sequence covers reset in the middle of a packet.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lupdate;

    localparam logic [47:0] c_MAC = 48'h0200_1234_5678;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_lu_data_wr;
    logic [133:0] in_lu_data;
    logic         in_lu_data_valid;
    logic         in_lu_data_valid_wr;
    logic [47:0]  in_local_mac_id;
    logic         out_lu_data_wr;
    logic [133:0] out_lu_data;
    logic         out_lu_data_valid;
    logic         out_lu_data_valid_wr;
    logic         direction;
    logic [31:0]  token_bucket_para;
    logic [47:0]  direct_mac_addr;
    logic [31:0]  time_slot_period;
    logic         beacon_update_master;
    logic [31:0]  upd_cnt;
    logic [31:0]  upd_err_cnt;

    always #5 clk = ~clk;

    lupdate dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_lu_data_wr        (in_lu_data_wr),
        .in_lu_data           (in_lu_data),
        .in_lu_data_valid     (in_lu_data_valid),
        .in_lu_data_valid_wr  (in_lu_data_valid_wr),
        .in_local_mac_id      (in_local_mac_id),
        .out_lu_data_wr       (out_lu_data_wr),
        .out_lu_data          (out_lu_data),
        .out_lu_data_valid    (out_lu_data_valid),
        .out_lu_data_valid_wr (out_lu_data_valid_wr),
        .direction            (direction),
        .token_bucket_para    (token_bucket_para),
        .direct_mac_addr      (direct_mac_addr),
        .time_slot_period     (time_slot_period),
        .beacon_update_master (beacon_update_master),
        .upd_cnt              (upd_cnt),
        .upd_err_cnt          (upd_err_cnt)
    );

    typedef struct packed {
        logic         wr;
        logic [133:0] d;
        logic         v;
        logic         vwr;
    } word_t;

    typedef struct packed {
        logic [47:0] mac;
        logic        dir;
        logic [31:0] tb;
        logic [31:0] ts;
        logic        tog;
        logic [31:0] uc;
        logic [31:0] ec;
    } regs_t;

    typedef struct {
        int          len;
        logic [15:0] eth;
        logic        mac_ok;
        logic [127:0] bcn;
        int          gap;
        logic [31:0] exp_uc;
        logic [31:0] exp_ec;
        logic        exp_tog;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] uc;
        logic [31:0] ec;
        logic        tog;
    } ckpt_t;

    word_t stim[$];
    word_t exp_out[$];
    regs_t exp_regs[$];
    ckpt_t ckpts[$];
    regs_t m;
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic regs_t dut_regs();
        regs_t r;
        r.mac = direct_mac_addr;
        r.dir = direction;
        r.tb  = token_bucket_para;
        r.ts  = time_slot_period;
        r.tog = beacon_update_master;
        r.uc  = upd_cnt;
        r.ec  = upd_err_cnt;
        return r;
    endfunction

    function automatic word_t dut_out();
        word_t w;
        w.wr  = out_lu_data_wr;
        w.d   = out_lu_data;
        w.v   = out_lu_data_valid;
        w.vwr = out_lu_data_valid_wr;
        return w;
    endfunction

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) begin
            stim.push_back('0);
            exp_out.push_back('0);
            exp_regs.push_back(m);
        end
    endtask

    // Builds one packet, and from packet-level rules its expected output
    // words and register effect at the tail.
    task automatic add_pkt(input int len, input logic [15:0] eth, input logic mac_ok,
                           input logic [3:0] typ, input logic [127:0] bcn, input int gap,
                           output int tail_idx);
        word_t       words[16];
        logic [127:0] p;
        logic [1:0]  mk;
        logic [47:0] dmac;
        logic        is_upd;
        dmac = mac_ok ? c_MAC : (c_MAC ^ 48'h0000_0000_0100);
        for (int k = 0; k < len; k++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            if (k == 2) p = {dmac, 48'h0a00_0000_0001, eth, 4'h0, typ, 8'h00};
            if (k == 6) p = bcn;
            mk = (k == 0) ? 2'b01 : (k == len - 1) ? 2'b10 : 2'b11;
            words[k].wr  = 1'b1;
            words[k].d   = {mk, 4'h0, p};
            words[k].vwr = (k == len - 1);
            words[k].v   = (k == len - 1) && ($urandom_range(0, 1) == 1);
        end
        is_upd = (len >= 3) && mac_ok && (eth == 16'h88f7) && (typ == 4'hd);
        for (int k = 0; k < len; k++) begin
            stim.push_back(words[k]);
            exp_out.push_back(is_upd ? word_t'('0) : words[k]);
            if (k == len - 1 && is_upd) begin
                if (len >= 7) begin
                    m.mac = bcn[127:80];
                    m.dir = bcn[79];
                    m.tb  = bcn[63:32];
                    m.ts  = bcn[31:0];
                    m.tog = ~m.tog;
                    m.uc  = m.uc + 1;
                end else begin
                    m.ec = m.ec + 1;
                end
            end
            exp_regs.push_back(m);
        end
        tail_idx = stim.size() - 1;
        push_idle(gap);
    endtask

    vec_t tbl[8];
    int   tail;
    int   ck_i;
    word_t w;

    initial begin
        // Directed vectors: {len, ethertype, dmac ok, beacon, gap, expected counters/toggle}
        tbl[0] = '{8,  16'h0800, 1'b1, 128'h0, 2, 32'd0, 32'd0, 1'b0};
        tbl[1] = '{13, 16'h88f7, 1'b1, {48'h0a0b0c0d0e0f, 1'b1, 15'b0, 32'h00010002, 32'd125000}, 2, 32'd1, 32'd0, 1'b1};
        tbl[2] = '{5,  16'h88f7, 1'b1, 128'h0, 2, 32'd1, 32'd1, 1'b1};
        tbl[3] = '{9,  16'h88f7, 1'b0, 128'h1111, 2, 32'd1, 32'd1, 1'b1};
        tbl[4] = '{7,  16'h88f7, 1'b1, {48'h1234_5678_9abc, 1'b0, 15'h7fff, 32'hdead_beef, 32'h0000_0400}, 0, 32'd2, 32'd1, 1'b0};
        tbl[5] = '{6,  16'h0800, 1'b1, 128'h0, 0, 32'd2, 32'd1, 1'b0};
        tbl[6] = '{10, 16'h88f7, 1'b1, {48'hcafe_0000_0001, 1'b1, 15'h0, 32'h0000_0010, 32'h0001_0000}, 3, 32'd3, 32'd1, 1'b1};
        tbl[7] = '{2,  16'h88f7, 1'b1, 128'h0, 1, 32'd3, 32'd1, 1'b1};

        m = '0;
        for (int r = 0; r < 8; r++) begin
            add_pkt(tbl[r].len, tbl[r].eth, tbl[r].mac_ok, 4'hd, tbl[r].bcn, tbl[r].gap, tail);
            ckpts.push_back('{tail, tbl[r].exp_uc, tbl[r].exp_ec, tbl[r].exp_tog});
        end
        for (int r = 0; r < 40; r++) begin
            add_pkt($urandom_range(2, 12),
                    ($urandom_range(0, 1) == 1) ? 16'h88f7 : 16'($urandom),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) != 0) ? 4'hd : 4'($urandom),
                    {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 2), tail);
        end
        push_idle(6);

        // Reset
        in_lu_data_wr       = 1'b0;
        in_lu_data          = '0;
        in_lu_data_valid    = 1'b0;
        in_lu_data_valid_wr = 1'b0;
        in_local_mac_id     = c_MAC;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out", 200'(dut_out()), 200'(0));
        chk("reset_regs", 200'(dut_regs()), 200'(0));
        rst = 1'b0;

        ck_i = 0;
        for (int i = 0; i < stim.size(); i++) begin
            if (i > 0) begin
                @(negedge clk);
                chk("regs", 200'(dut_regs()), 200'(exp_regs[i-1]));
                if (ck_i < ckpts.size() && ckpts[ck_i].cyc == i - 1) begin
                    chk("tbl_upd_cnt", 200'(upd_cnt), 200'(ckpts[ck_i].uc));
                    chk("tbl_err_cnt", 200'(upd_err_cnt), 200'(ckpts[ck_i].ec));
                    chk("tbl_toggle", 200'(beacon_update_master), 200'(ckpts[ck_i].tog));
                    ck_i++;
                end
            end
            if (i >= 4) chk("out_word", 200'(dut_out()), 200'(exp_out[i-4]));
            w = stim[i];
            in_lu_data_wr       = w.wr;
            in_lu_data          = w.d;
            in_lu_data_valid    = w.v;
            in_lu_data_valid_wr = w.vwr;
        end
        chk("tbl_all_seen", 200'(ck_i), 200'(8));

        // Reset in the middle of an update packet whose beacon word is
        // already latched; the tail after reset must not commit.
        stim.delete();
        exp_out.delete();
        exp_regs.delete();
        m = '0;
        add_pkt(10, 16'h88f7, 1'b1, 4'hd, {48'h7777_8888_9999, 1'b1, 15'h0, 32'h5, 32'h6}, 0, tail);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 8) begin
                rst = 1'b1;
                #1;
                chk("midrst_out_wr", 200'(out_lu_data_wr), 200'(0));
                chk("midrst_regs", 200'(dut_regs()), 200'(0));
                @(negedge clk);
                rst = 1'b0;
            end
            w = stim[i];
            in_lu_data_wr       = w.wr;
            in_lu_data          = w.d;
            in_lu_data_valid    = w.v;
            in_lu_data_valid_wr = w.vwr;
        end
        @(negedge clk);
        in_lu_data_wr       = 1'b0;
        in_lu_data          = '0;
        in_lu_data_valid    = 1'b0;
        in_lu_data_valid_wr = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_no_commit", 200'(dut_regs()), 200'(0));
        chk("midrst_idle_out", 200'(dut_out()), 200'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lupdate.md
# lupdate

Beacon-update receiver for the LCM path. It sits on the 134-bit packet stream coming from the CNC side and classifies each packet at its Ethernet header. Beacon-update messages addressed to this node are consumed: their beacon field is written into the local configuration registers and `beacon_update_master` is toggled so the report side can acknowledge the update. All other packets pass through unchanged with a fixed 4-cycle latency.

## Interface
- `ETH_TYPE`, 16'h88f7, ethertype that marks a beacon message.
- `UPD_TYPE`, 4'hd, message-type nibble that marks a beacon update.
- `MIN_WORDS`, 7, minimum word count of a complete update (head through beacon word 6).
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_lu_data_wr` in 1: input word strobe. Words of one packet are contiguous.
- `in_lu_data` in 134: input word. [133:132] is the marker: 01 head, 11 middle, 10 tail. [131:128] reserved. [127:0] payload.
- `in_lu_data_valid` in 1: packet-valid, sampled with `in_lu_data_valid_wr`.
- `in_lu_data_valid_wr` in 1: packet-valid strobe, asserted on the tail word.
- `in_local_mac_id` in 48: this node's MAC address. Quasi-static.
- `out_lu_data_wr` out 1: forwarded word strobe.
- `out_lu_data` out 134: forwarded word.
- `out_lu_data_valid` out 1: forwarded packet-valid.
- `out_lu_data_valid_wr` out 1: forwarded packet-valid strobe.
- `direction` out 1: beacon register.
- `token_bucket_para` out 32: beacon register.
- `direct_mac_addr` out 48: beacon register.
- `time_slot_period` out 32: beacon register.
- `beacon_update_master` out 1: toggles once per committed update.
- `upd_cnt` out 32: number of committed updates, wraps.
- `upd_err_cnt` out 32: number of truncated updates, wraps.

## Operation
- **Word numbering.** Word 0 is the head. Words 0–1 are metadata.
- **Word 2, Ethernet header:**
  - [127:80] dmac
  - [79:32] smac
  - [31:16] ethertype
  - [11:8] type
- **Update match.** A packet is an update when all three hold on word 2: dmac == `in_local_mac_id`, ethertype == `ETH_TYPE`, and type == `UPD_TYPE`.
- **Word 6, beacon field:**
  - [127:80] `direct_mac_addr`
  - [79] `direction`
  - [78:64] reserved
  - [63:32] `token_bucket_para`
  - [31:0] `time_slot_period`
- **Data path.** A 3-stage delay line s0 → s1 → s2 carries {wr, data, valid, valid_wr} every cycle, followed by an output register. Classification is made combinationally from s0 in the cycle word 2 sits there; at that point the head is in s2. The result is latched into `drop_flag`.
  - `drop_flag` = 1: the output register loads all-zero with wr = 0 for every word of that packet.
  - `drop_flag` clears on the cycle the tail leaves s2.
- **Short packets.** A packet with fewer than 3 words is never an update and is forwarded.
- **Receive FSM**, stepping on `in_lu_data_wr`:
  - IDLE: a head moves to HDR, word counter = 1.
  - HDR: counts words 1–2. At word 2 the FSM goes to UPD if the packet matches, otherwise to FWD. A tail seen in HDR returns to IDLE.
  - FWD: stays until the tail, then returns to IDLE.
  - UPD: word 6 is latched into shadow registers and `shadow_ok` is set. On the tail:
    - if `shadow_ok` = 1, commit: copy shadow to the outputs, toggle `beacon_update_master`, `upd_cnt`++.
    - otherwise `upd_err_cnt`++ and nothing else changes.
    - Either way, return to IDLE.
- **Tail `valid` is ignored for commit.** The marker alone ends the packet.
- **Extra words.** Words beyond 6 in an update packet are ignored.
- **Head while not in IDLE.** A head arriving in any state other than IDLE is treated as a new packet. The abandoned update is not committed and is not counted.

## Timing
- **Reset values.** All outputs are 0, including `beacon_update_master` and both counters. The FSM resets to IDLE and the delay line and `drop_flag` reset to 0.
- **Forward latency.** An input word at cycle t appears on `out_lu_*` at cycle t+4.
- **Gaps.** Gaps between packets are preserved.
- **Commit latency.** With the tail accepted at cycle T, the beacon registers, the toggle and `upd_cnt` show the new values at T+1.
- **Back-to-back packets** (head directly after tail) are handled with zero bubble.
- **Reset mid-packet.** The packet is lost, no commit happens, and the output returns to idle immediately.
- **Counter wrap.** Both counters wrap from 0xFFFFFFFF to 0 without side effects.

## Test plan
- **Reset check.** Assert `rst` for 3 cycles → all outputs 0 and `out_lu_data_wr` = 0.
- **Forwarded packet.** Send an 8-word non-update packet (ethertype 16'h0800) → identical 8 words on the output starting 4 cycles after input; beacon registers unchanged.
- **Valid update.** Send a 13-word update with dmac = `in_local_mac_id`, word 6 = {48'h0a0b0c0d0e0f, 1, 15'b0, 32'h00010002, 32'd125000} → no output words. At tail+1: `direct_mac_addr` = 48'h0a0b0c0d0e0f, `direction` = 1, `token_bucket_para` = 32'h00010002, `time_slot_period` = 125000, `beacon_update_master` 0→1, `upd_cnt` = 1.
- **Truncated update.** Send an update whose tail is word 4 → dropped, registers unchanged, `upd_err_cnt` = 1, toggle unchanged.
- **Wrong dmac.** Send an update-format packet with dmac ≠ local MAC → forwarded intact with 4-cycle latency, `upd_cnt` unchanged.
- **Mixed traffic and counter wrap.** Send back-to-back update, forward, update, no gaps → only the forward packet appears on the output, the toggle returns to its original value after two commits, `upd_cnt` += 2. Separately, preload-style test: run 2^32 commits in a forced model → `upd_cnt` wraps to 0.
